// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor.
//   NIBBLE_W : width of the slice processed per clock
//   state_t  : control FSM states
//   idx_w()  : width of the nibble index counter for a given operand width
package sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width needed to count WIDTH/4 nibbles. WIDTH >= 8 gives at least 2 nibbles,
    // so this never collapses to 0, but the floor keeps the counter legal.
    function automatic int idx_w(input int width);
        return (width / NIBBLE_W > 1) ? $clog2(width / NIBBLE_W) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_subtractor_borrow_look_ahead.sv
// Combinational 4-bit subtract slice: d = a - b - bin, with the borrow resolved
// by a carry-lookahead chain on a + ~b + ~bin.
//   a, b : nibble operands
//   bin  : borrow in
//   d    : nibble difference
//   bout : borrow out (inverse of the adder carry out)
module borrow_look_ahead
    import sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                bin,
    output logic [NIBBLE_W-1:0] d,
    output logic                bout
);

    logic [3:0] g, p, nb;
    logic [4:0] c;

    assign nb = ~b;
    assign g  = a & nb;
    assign p  = a | nb;

    // Subtraction as addition: carry in is the inverted borrow.
    assign c[0] = ~bin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & (g[2] | (p[2] & (g[1] | (p[1] & (g[0] | (p[0] & c[0])))))));

    assign d    = a ^ nb ^ c[3:0];
    assign bout = ~c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, D = A - B - BI, one nibble per clock, LSB first.
// Operands are latched on an accepted start; done pulses one cycle with the result.
// Optional feature macro: SUB_OVERFLOW_EN (signed overflow flag on V; otherwise V=0).
//   clk, rst_n : clock, async active-low reset
//   start      : request, accepted in IDLE or DONE
//   A, B, BI   : minuend, subtrahend, borrow in
//   busy       : high while nibbles are being processed
//   done       : one-cycle result-valid pulse
//   D, BO, V   : difference, borrow out, signed overflow (held until next start)
module nibble_serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BI,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             BO,
    output logic             V
);

    localparam int N    = WIDTH / NIBBLE_W;
    localparam int IDXW = idx_w(WIDTH);

    state_t state, state_nxt;

    logic [WIDTH-1:0]    a_q, b_q, d_q;
    logic [IDXW-1:0]     idx;
    logic                borrow, bo_q;
    logic                accept, last;
    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_d;
    logic                nib_bout;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == RUN) && (idx == IDXW'(N - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Single slice shared across all nibble positions.
    assign nib_a = a_q[{idx, 2'b00} +: NIBBLE_W];
    assign nib_b = b_q[{idx, 2'b00} +: NIBBLE_W];

    borrow_look_ahead u_bla (
        .a    (nib_a),
        .b    (nib_b),
        .bin  (borrow),
        .d    (nib_d),
        .bout (nib_bout)
    );

    // Datapath. The borrow register is preloaded with BI so nibble 0 needs no
    // special case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            bo_q   <= 1'b0;
        end else if (accept) begin
            a_q    <= A;
            b_q    <= B;
            borrow <= BI;
            d_q    <= '0;
            idx    <= '0;
        end else if (state == RUN) begin
            d_q[{idx, 2'b00} +: NIBBLE_W] <= nib_d;
            borrow <= nib_bout;
            if (last) begin
                bo_q <= nib_bout;
                idx  <= '0;
            end else begin
                idx  <= idx + 1'b1;
            end
        end
    end

`ifdef SUB_OVERFLOW_EN
    logic v_q;

    // Overflow when operand signs differ and the result sign differs from A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    v_q <= 1'b0;
        else if (last) v_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ nib_d[NIBBLE_W-1]);
    end

    assign V = v_q;
`else
    assign V = 1'b0;
`endif

    assign D  = d_q;
    assign BO = bo_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A, B;
    logic             BI;
    logic             busy, done, BO, V;
    logic [WIDTH-1:0] D;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

`ifdef SUB_OVERFLOW_EN
    localparam logic V_EN = 1'b1;
`else
    localparam logic V_EN = 1'b0;
`endif

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .BI    (BI),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .BO    (BO),
        .V     (V)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait for done; reports latency in edges after edge 0.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                          output int lat);
        @(negedge clk);
        A = a; B = b; BI = bi; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            lat++;
        end
        if (!done) chk("timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int lat;
        int t_done [3];
        int nd;
        logic [15:0] opa [3], opb [3], expd [3];
        logic        opi [3], expb [3];

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; BI = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_D",    32'(D),    0);
        chk("rst_BO",   32'(BO),   0);
        chk("rst_V",    32'(V),    0);
        rst_n = 1'b1;

        // Basic subtract, latency N = 4
        run_op(16'h1234, 16'h0234, 1'b0, lat);
        chk("t1_lat",  32'(lat), 4);
        chk("t1_D",    32'(D),   32'h1000);
        chk("t1_BO",   32'(BO),  0);
        chk("t1_busy", 32'(busy), 0);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_D_hold",     32'(D),    32'h1000);

        // Borrow ripples through every nibble
        run_op(16'h0000, 16'h0001, 1'b0, lat);
        chk("t2_D",  32'(D),  32'hFFFF);
        chk("t2_BO", 32'(BO), 1);
        chk("t2_V",  32'(V),  0);

        // Reset mid-RUN: everything clears without a clock edge
        @(negedge clk);
        A = 16'h5555; B = 16'h1111; BI = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 chk("rst_mid_D_partial", 32'(D), 32'h0004);
        chk("rst_mid_busy_pre", 32'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_done", 32'(done), 0);
        chk("rst_mid_D",    32'(D),    0);
        chk("rst_mid_BO",   32'(BO),   0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("rst_no_done", 32'(nd), 0);

        // Signed overflow cases
        run_op(16'h8000, 16'h0001, 1'b0, lat);
        chk("ov1_D",  32'(D),  32'h7FFF);
        chk("ov1_BO", 32'(BO), 0);
        chk("ov1_V",  32'(V),  32'(V_EN));
        run_op(16'h0005, 16'h0003, 1'b1, lat);
        chk("ov2_D",  32'(D),  32'h0001);
        chk("ov2_BO", 32'(BO), 0);
        chk("ov2_V",  32'(V),  0);

        // Start during RUN is ignored
        @(negedge clk);
        A = 16'h00FF; B = 16'h000F; BI = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 A = 16'hFFFF; B = 16'h0000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 2;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            lat++;
        end
        chk("ign_done", 32'(done), 1);
        chk("ign_lat",  32'(lat),  4);
        chk("ign_D",    32'(D),    32'h00F0);
        chk("ign_BO",   32'(BO),   0);

        // Back-to-back with start held high
        opa[0] = 16'h1234; opb[0] = 16'h0234; opi[0] = 1'b0; expd[0] = 16'h1000; expb[0] = 1'b0;
        opa[1] = 16'h0000; opb[1] = 16'h0001; opi[1] = 1'b0; expd[1] = 16'hFFFF; expb[1] = 1'b1;
        opa[2] = 16'hABCD; opb[2] = 16'h1111; opi[2] = 1'b1; expd[2] = 16'h9ABB; expb[2] = 1'b0;
        @(negedge clk);
        A = opa[0]; B = opb[0]; BI = opi[0]; start = 1'b1;
        nd = 0;
        for (int k = 0; k < 40 && nd < 3; k++) begin
            @(negedge clk);
            if (done) begin
                t_done[nd] = cyc;
                chk($sformatf("b2b%0d_D", nd),  32'(D),  32'(expd[nd]));
                chk($sformatf("b2b%0d_BO", nd), 32'(BO), 32'(expb[nd]));
                nd++;
                if (nd < 3) begin
                    A = opa[nd]; B = opb[nd]; BI = opi[nd];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(nd), 3);
        if (nd == 3) begin
            chk("b2b_gap01", 32'(t_done[1] - t_done[0]), 5);
            chk("b2b_gap12", 32'(t_done[2] - t_done[1]), 5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
